// File: rtl/mbisr_pkg.sv
// rtl/mbisr_pkg.sv - shared constants and spare-entry type for the repair memory
package mbisr_pkg;

  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_NUM_SPARES = 2;
  localparam int CNT_W          = 3;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] tag;
    logic [DEF_DATA_W-1:0] data;
  } spare_t;

endpackage

// File: rtl/mbisr_repair_mem_if.sv
// rtl/mbisr_repair_mem_if.sv - engine-to-memory access, repair and fault-injection bus
interface mbisr_repair_mem_if
  import mbisr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              ena;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              rep_req;
  logic [ADDR_W-1:0] rep_addr;
  logic              rep_ack;
  logic              rep_ovf;
  logic [CNT_W-1:0]  repair_cnt;
  logic              inj_en;
  logic [ADDR_W-1:0] inj_addr;
  logic [2:0]        inj_bit;
  logic              inj_val;

  modport master (
    output ena, mem_en, mem_we, mem_addr, mem_wdata,
    output rep_req, rep_addr,
    output inj_en, inj_addr, inj_bit, inj_val,
    input  mem_rdata, mem_rvalid, rep_ack, rep_ovf, repair_cnt
  );

  modport slave (
    input  ena, mem_en, mem_we, mem_addr, mem_wdata,
    input  rep_req, rep_addr,
    input  inj_en, inj_addr, inj_bit, inj_val,
    output mem_rdata, mem_rvalid, rep_ack, rep_ovf, repair_cnt
  );

endinterface

// File: rtl/mbisr_remap_cam.sv
// rtl/mbisr_remap_cam.sv - spare-word tag store: lookup, lowest-free allocation, spare writes
module mbisr_remap_cam
  import mbisr_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_SPARES = DEF_NUM_SPARES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rep_addr,
  output logic              rep_hit,
  output logic              has_free,
  input  logic              alloc_en
);

  spare_t spares [NUM_SPARES];
  int     lk_idx;
  int     free_idx;

  // Scanning from the top down leaves the lowest matching / free index selected.
  always_comb begin
    lk_hit   = 1'b0;
    lk_idx   = 0;
    lk_data  = '0;
    rep_hit  = 1'b0;
    has_free = 1'b0;
    free_idx = 0;
    for (int i = NUM_SPARES - 1; i >= 0; i--) begin
      if (spares[i].valid && spares[i].tag == lk_addr) begin
        lk_hit  = 1'b1;
        lk_idx  = i;
        lk_data = spares[i].data;
      end
      if (spares[i].valid && spares[i].tag == rep_addr) begin
        rep_hit = 1'b1;
      end
      if (!spares[i].valid) begin
        has_free = 1'b1;
        free_idx = i;
      end
    end
  end

  // Allocation only targets an invalid entry and writes only hit valid ones, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPARES; i++) begin
        spares[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPARES; i++) begin
        if (alloc_en && i == free_idx) begin
          spares[i] <= '{valid: 1'b1, tag: rep_addr, data: '0};
        end else if (wr_en && lk_hit && i == lk_idx) begin
          spares[i].data <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/mbisr_repair_mem.sv
// rtl/mbisr_repair_mem.sv - BIST-facing SRAM model with spare-word remapping and a stuck-at injector
module mbisr_repair_mem
  import mbisr_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_SPARES = DEF_NUM_SPARES
) (
  input logic               clk,
  input logic               rst_n,
  mbisr_repair_mem_if.slave bus
);

  localparam int WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] main_mem [WORDS];
  logic              acc_wr;
  logic              acc_rd;
  logic              rep_acc;
  logic              lk_hit;
  logic [DATA_W-1:0] spare_rdata;
  logic              rep_hit;
  logic              has_free;
  logic              alloc_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              ack_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  cnt_q;

  assign acc_wr   = bus.ena & bus.mem_en & bus.mem_we;
  assign acc_rd   = bus.ena & bus.mem_en & ~bus.mem_we;
  assign rep_acc  = bus.ena & bus.rep_req;
  assign alloc_en = rep_acc & ~rep_hit & has_free;

  mbisr_remap_cam #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .NUM_SPARES(NUM_SPARES)
  ) u_cam (
    .clk     (clk),
    .rst_n   (rst_n),
    .lk_addr (bus.mem_addr),
    .lk_hit  (lk_hit),
    .lk_data (spare_rdata),
    .wr_en   (acc_wr),
    .wr_data (bus.mem_wdata),
    .rep_addr(bus.rep_addr),
    .rep_hit (rep_hit),
    .has_free(has_free),
    .alloc_en(alloc_en)
  );

  // The stuck bit only corrupts main-array reads; the bit loop drops out-of-range indices.
  always_comb begin
    rd_data = lk_hit ? spare_rdata : main_mem[bus.mem_addr];
    if (!lk_hit && bus.inj_en && bus.mem_addr == bus.inj_addr) begin
      for (int b = 0; b < DATA_W; b++) begin
        if (b == int'(bus.inj_bit)) begin
          rd_data[b] = bus.inj_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        main_mem[i] <= '0;
      end
    end else if (acc_wr && !lk_hit) begin
      main_mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rvalid_q <= acc_rd;
      ack_q    <= rep_acc;
      if (acc_rd) begin
        rdata_q <= rd_data;
      end
      if (alloc_en) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (rep_acc && !rep_hit) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.mem_rdata  = rdata_q;
  assign bus.mem_rvalid = rvalid_q;
  assign bus.rep_ack    = ack_q;
  assign bus.rep_ovf    = ovf_q;
  assign bus.repair_cnt = cnt_q;

endmodule

// File: tb/tb_mbisr_repair_mem.sv
// tb/tb_mbisr_repair_mem.sv - vector table, corner sequences and random run against a reference model
module tb_mbisr_repair_mem;

  localparam int NS = 2;

  typedef struct {
    logic       ena, men, we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       rq;
    logic [3:0] raddr;
    logic       ien;
    logic [3:0] iaddr;
    logic [2:0] ibit;
    logic       ival;
    logic       e_rv;
    logic [7:0] e_rd;
    logic       e_ack;
    logic [2:0] e_cnt;
    logic       e_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_main [16];
  logic [3:0] m_tag [$];
  logic [7:0] m_dat [$];
  logic [7:0] m_rd;
  logic       m_ovf;

  mbisr_repair_mem_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  mbisr_repair_mem #(.ADDR_W(4), .DATA_W(8), .NUM_SPARES(NS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic ena, logic men, logic we, logic [3:0] addr, logic [7:0] wdata,
                              logic rq, logic [3:0] raddr, logic ien, logic [3:0] iaddr,
                              logic [2:0] ibit, logic ival, logic e_rv, logic [7:0] e_rd,
                              logic e_ack, logic [2:0] e_cnt, logic e_ovf);
    vec_t v;
    v.ena = ena; v.men = men; v.we = we; v.addr = addr; v.wdata = wdata;
    v.rq = rq; v.raddr = raddr; v.ien = ien; v.iaddr = iaddr; v.ibit = ibit; v.ival = ival;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_ack = e_ack; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(string name, logic rv, logic [7:0] rd, logic ack, logic [2:0] cnt, logic ovf);
    chk({name, "_rvalid"}, 32'(bus.mem_rvalid), 32'(rv));
    chk({name, "_rdata"},  32'(bus.mem_rdata),  32'(rd));
    chk({name, "_ack"},    32'(bus.rep_ack),    32'(ack));
    chk({name, "_cnt"},    32'(bus.repair_cnt), 32'(cnt));
    chk({name, "_ovf"},    32'(bus.rep_ovf),    32'(ovf));
  endtask

  task automatic drive(vec_t v);
    bus.ena = v.ena; bus.mem_en = v.men; bus.mem_we = v.we; bus.mem_addr = v.addr;
    bus.mem_wdata = v.wdata; bus.rep_req = v.rq; bus.rep_addr = v.raddr;
    bus.inj_en = v.ien; bus.inj_addr = v.iaddr; bus.inj_bit = v.ibit; bus.inj_val = v.ival;
  endtask

  task automatic apply(vec_t v, string name);
    drive(v);
    @(posedge clk);
    #1;
    check_outs(name, v.e_rv, v.e_rd, v.e_ack, v.e_cnt, v.e_ovf);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_main[i] = 8'h00;
    m_tag.delete();
    m_dat.delete();
    m_rd  = 8'h00;
    m_ovf = 1'b0;
  endtask

  function automatic int m_find(logic [3:0] a);
    foreach (m_tag[i]) if (m_tag[i] == a) return i;
    return -1;
  endfunction

  // Spares are never freed, so allocation order equals spare index order.
  function automatic vec_t model(vec_t v);
    int         s;
    logic [7:0] d;
    if (v.ena) begin
      s = m_find(v.addr);
      if (v.men && !v.we) begin
        d = (s >= 0) ? m_dat[s] : m_main[v.addr];
        if (s < 0 && v.ien && v.addr == v.iaddr) d[v.ibit] = v.ival;
        m_rd = d;
      end
      if (v.men && v.we) begin
        if (s >= 0) m_dat[s] = v.wdata;
        else        m_main[v.addr] = v.wdata;
      end
      if (v.rq && m_find(v.raddr) < 0) begin
        if (m_tag.size() < NS) begin
          m_tag.push_back(v.raddr);
          m_dat.push_back(8'h00);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    v.e_rv  = v.ena & v.men & ~v.we;
    v.e_ack = v.ena & v.rq;
    v.e_rd  = m_rd;
    v.e_cnt = 3'(m_tag.size());
    v.e_ovf = m_ovf;
    return v;
  endfunction

  task automatic do_reset();
    drive(mk(0,0,0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl [$];
  vec_t v;

  initial begin
    //          ena men we adr wdata  rq radr ien iad bit val  rv  rd    ack cnt ovf
    tbl.push_back(mk(1,1,1, 3, 8'hA5, 0, 0,  0, 0, 0, 0,  0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,1,0, 3, 8'h00, 0, 0,  0, 0, 0, 0,  1, 8'hA5, 0, 0, 0));
    tbl.push_back(mk(1,1,0, 4, 8'h00, 0, 0,  0, 0, 0, 0,  1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,1,1, 5, 8'hFF, 0, 0,  1, 5, 0, 0,  0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,1,0, 5, 8'h00, 0, 0,  1, 5, 0, 0,  1, 8'hFE, 0, 0, 0));
    tbl.push_back(mk(1,0,0, 0, 8'h00, 1, 5,  1, 5, 0, 0,  0, 8'hFE, 1, 1, 0));
    tbl.push_back(mk(1,1,1, 5, 8'hFF, 0, 0,  1, 5, 0, 0,  0, 8'hFE, 0, 1, 0));
    tbl.push_back(mk(1,1,0, 5, 8'h00, 0, 0,  1, 5, 0, 0,  1, 8'hFF, 0, 1, 0));
    tbl.push_back(mk(1,0,0, 0, 8'h00, 1, 5,  0, 0, 0, 0,  0, 8'hFF, 1, 1, 0));
    tbl.push_back(mk(1,0,0, 0, 8'h00, 0, 0,  0, 0, 0, 0,  0, 8'hFF, 0, 1, 0));
    tbl.push_back(mk(1,0,0, 0, 8'h00, 1, 5,  0, 0, 0, 0,  0, 8'hFF, 1, 1, 0));
    tbl.push_back(mk(1,0,0, 0, 8'h00, 1, 9,  0, 0, 0, 0,  0, 8'hFF, 1, 2, 0));
    tbl.push_back(mk(1,0,0, 0, 8'h00, 1, 12, 0, 0, 0, 0,  0, 8'hFF, 1, 2, 1));
    tbl.push_back(mk(1,1,1, 12,8'h3C, 0, 0,  0, 0, 0, 0,  0, 8'hFF, 0, 2, 1));
    tbl.push_back(mk(1,1,0, 12,8'h00, 0, 0,  0, 0, 0, 0,  1, 8'h3C, 0, 2, 1));
    tbl.push_back(mk(1,1,0, 12,8'h00, 0, 0,  1, 12,0, 1,  1, 8'h3D, 0, 2, 1));
    tbl.push_back(mk(0,1,0, 3, 8'h00, 1, 3,  0, 0, 0, 0,  0, 8'h3D, 0, 2, 1));
    tbl.push_back(mk(0,1,1, 3, 8'h77, 0, 0,  0, 0, 0, 0,  0, 8'h3D, 0, 2, 1));
    tbl.push_back(mk(1,1,0, 3, 8'h00, 0, 0,  0, 0, 0, 0,  1, 8'hA5, 0, 2, 1));

    do_reset();
    #1;
    check_outs("reset", 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Read racing a repair of the same address, then repair racing a write.
    do_reset();
    apply(mk(1,1,1, 5, 8'hFF, 0, 0, 1, 5, 0, 0,  0, 8'h00, 0, 0, 0), "race_wr");
    apply(mk(1,1,0, 5, 8'h00, 1, 5, 1, 5, 0, 0,  1, 8'hFE, 1, 1, 0), "race_rd_rep");
    apply(mk(1,1,0, 5, 8'h00, 0, 0, 1, 5, 0, 0,  1, 8'h00, 0, 1, 0), "race_after");
    apply(mk(1,1,1, 7, 8'h44, 1, 7, 0, 0, 0, 0,  0, 8'h00, 1, 2, 0), "rep_wr_same");
    apply(mk(1,1,0, 7, 8'h00, 0, 0, 0, 0, 0, 0,  1, 8'h00, 0, 2, 0), "rep_wr_rd");
    apply(mk(1,1,0, 5, 8'h00, 0, 0, 0, 0, 0, 0,  1, 8'h00, 0, 2, 0), "pre_rst_rd");

    // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1,1,1, 5, 8'hFF, 0, 0, 1, 5, 0, 0,  0, 8'h00, 0, 0, 0), "post_rst_wr");
    apply(mk(1,1,0, 5, 8'h00, 0, 0, 1, 5, 0, 0,  1, 8'hFE, 0, 0, 0), "post_rst_rd");
    apply(mk(0,1,0, 5, 8'h00, 1, 5, 1, 5, 0, 0,  0, 8'hFE, 0, 0, 0), "ena_off");
    apply(mk(1,1,0, 5, 8'h00, 0, 0, 1, 5, 0, 0,  1, 8'hFE, 0, 0, 0), "ena_off_chk");

    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      v.ena   = ($urandom_range(0, 9) != 0);
      v.men   = 1'($urandom);
      v.we    = 1'($urandom);
      v.addr  = 4'($urandom_range(0, 7));
      v.wdata = 8'($urandom);
      v.rq    = ($urandom_range(0, 4) == 0);
      v.raddr = 4'($urandom_range(0, 7));
      v.ien   = 1'($urandom);
      v.iaddr = 4'($urandom_range(0, 7));
      v.ibit  = 3'($urandom);
      v.ival  = 1'($urandom);
      v = model(v);
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
